terrain_crater_carver: RTL and testbench

- Upstream write-side client of the terrain column store: on a projectile impact it erases a filled disc of terrain around the impact point.
- Terrain is held as 512-bit columns, one per x address. Bit y = 1 means solid.
- For each affected column the block reads it, clears the bits inside the disc, and writes it back through the store's write port (we / write_addr / terrain_in).
- Only one crater is processed at a time; the game FSM starts it and waits for done.

---
 rtl/terrain_crater_carver.sv | 171 +++++++++++++++++
 tb/tb_terrain_crater_carver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/terrain_crater_carver.sv
// Crater carver: erases a filled disc of terrain around an impact point,
// one read-modify-write column at a time, in ascending x.
module terrain_crater_carver #(
    parameter int COLS   = 640,
    parameter int ROWS   = 512,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [9:0]   cx,
    input  logic [8:0]   cy,
    input  logic [5:0]   radius,
    output logic [9:0]   read_addr,
    input  logic [511:0] terrain_out,
    output logic         we,
    output logic [9:0]   write_addr,
    output logic [511:0] terrain_in,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        READ,
        SPAN,
        MASK,
        WRITE
    } state_t;

    localparam logic signed [10:0] X_MAX = 11'(COLS - 1);
    localparam logic [9:0]         Y_MAX = 10'(ROWS - 1);

    state_t       state;
    logic [9:0]   cx_q;
    logic [8:0]   cy_q;
    logic [5:0]   r_q;
    logic [9:0]   x_q;
    logic [9:0]   x_hi_q;
    logic [5:0]   h_q;
    logic [3:0]   rd_cnt;
    logic [511:0] col_q;

    logic signed [10:0] lo_s;
    logic signed [10:0] hi_s;
    logic [9:0]         x_lo_c;
    logic [9:0]         x_hi_c;

    // Column range, in signed 11 bits so cx-r and cx+r cannot wrap.
    always_comb begin
        lo_s   = $signed({1'b0, cx_q}) - $signed({5'b0, r_q});
        hi_s   = $signed({1'b0, cx_q}) + $signed({5'b0, r_q});
        x_lo_c = (lo_s < 0) ? 10'd0 : lo_s[9:0];
        x_hi_c = (hi_s > X_MAX) ? X_MAX[9:0] : hi_s[9:0];
    end

    logic [9:0]  dx;
    logic [6:0]  hp1;
    logic [12:0] hp1_sq;
    logic [12:0] dx_sq;
    logic [12:0] r_sq;
    logic        grow;

    always_comb begin
        dx     = (x_q >= cx_q) ? (x_q - cx_q) : (cx_q - x_q);
        hp1    = {1'b0, h_q} + 7'd1;
        hp1_sq = {6'b0, hp1} * {6'b0, hp1};
        dx_sq  = {3'b0, dx} * {3'b0, dx};
        r_sq   = {7'b0, r_q} * {7'b0, r_q};
        grow   = (hp1_sq + dx_sq) <= r_sq;
    end

    logic [8:0]   y_lo;
    logic [9:0]   y_sum;
    logic [8:0]   y_hi;
    logic [511:0] mask;

    always_comb begin
        y_lo  = (cy_q >= {3'b0, h_q}) ? (cy_q - {3'b0, h_q}) : 9'd0;
        y_sum = {1'b0, cy_q} + {4'b0, h_q};
        y_hi  = (y_sum > Y_MAX) ? Y_MAX[8:0] : y_sum[8:0];
        mask  = '0;
        for (int i = 0; i < ROWS; i++) begin
            mask[i] = (i >= int'(y_lo)) && (i <= int'(y_hi));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cx_q       <= '0;
            cy_q       <= '0;
            r_q        <= '0;
            x_q        <= '0;
            x_hi_q     <= '0;
            h_q        <= '0;
            rd_cnt     <= '0;
            col_q      <= '0;
            read_addr  <= '0;
            write_addr <= '0;
            terrain_in <= '0;
            we         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cx_q  <= cx;
                        cy_q  <= cy;
                        r_q   <= radius;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if ({1'b0, cx_q} >= 11'(COLS)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        x_q       <= x_lo_c;
                        x_hi_q    <= x_hi_c;
                        read_addr <= x_lo_c;
                        rd_cnt    <= '0;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (rd_cnt == 4'(RD_LAT)) begin
                        col_q <= terrain_out;
                        h_q   <= '0;
                        state <= SPAN;
                    end else begin
                        rd_cnt <= rd_cnt + 4'd1;
                    end
                end
                SPAN: begin
                    if (grow) begin
                        h_q <= h_q + 6'd1;
                    end else begin
                        state <= MASK;
                    end
                end
                MASK: begin
                    terrain_in <= col_q & ~mask;
                    write_addr <= x_q;
                    we         <= 1'b1;
                    state      <= WRITE;
                end
                WRITE: begin
                    if (x_q == x_hi_q) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        x_q       <= x_q + 10'd1;
                        read_addr <= x_q + 10'd1;
                        rd_cnt    <= '0;
                        state     <= READ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_terrain_crater_carver.sv
// Directed plus randomized checks of the crater carver against a
// disc-equation reference model and a simple column store.
module tb_terrain_crater_carver;

    localparam int NC = 640;
    localparam int NR = 512;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [9:0]   cx;
    logic [8:0]   cy;
    logic [5:0]   radius;
    logic [9:0]   read_addr;
    logic [511:0] terrain_out;
    logic         we;
    logic [9:0]   write_addr;
    logic [511:0] terrain_in;
    logic         busy;
    logic         done;

    logic         fill_en;
    logic         fill_rand;
    logic [511:0] mem [0:NC-1];

    int checks   = 0;
    int failures = 0;

    logic [9:0]   exp_a [$];
    logic [511:0] exp_d [$];
    int           exp_c [$];
    logic [9:0]   got_a [$];
    logic [511:0] got_d [$];
    int           got_c [$];

    terrain_crater_carver dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .cx(cx),
        .cy(cy),
        .radius(radius),
        .read_addr(read_addr),
        .terrain_out(terrain_out),
        .we(we),
        .write_addr(write_addr),
        .terrain_in(terrain_in),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Column store: one-cycle registered read, write on rising edge.
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < NC; i++)
                for (int j = 0; j < 16; j++)
                    mem[i][j*32 +: 32] <= fill_rand ? $urandom() : 32'hffff_ffff;
        end else if (we) begin
            mem[write_addr] <= terrain_in;
        end
        terrain_out <= mem[read_addr];
    end

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic rnd);
        @(negedge clk);
        fill_en   = 1'b1;
        fill_rand = rnd;
        @(negedge clk);
        fill_en = 1'b0;
    endtask

    // Reference: a bit (x,y) is inside the crater when
    // (x-cx)^2 + (y-cy)^2 <= r^2; write timing is h+5 cycles per column.
    task automatic build_expect(input int x0, input int y0, input int r);
        int t;
        int lo;
        int hi;
        exp_a.delete();
        exp_d.delete();
        exp_c.delete();
        if (x0 >= NC) return;
        lo = (x0 - r < 0) ? 0 : x0 - r;
        hi = (x0 + r > NC - 1) ? NC - 1 : x0 + r;
        t  = 0;
        for (int x = lo; x <= hi; x++) begin
            int dx2;
            int h;
            logic [511:0] d;
            dx2 = (x - x0) * (x - x0);
            h   = 0;
            while ((h + 1) * (h + 1) <= r * r - dx2) h++;
            d = mem[x];
            for (int y = 0; y < NR; y++)
                if ((y - y0) * (y - y0) + dx2 <= r * r) d[y] = 1'b0;
            t += h + 5;
            exp_a.push_back(10'(x));
            exp_d.push_back(d);
            exp_c.push_back(t);
        end
    endtask

    task automatic run_crater(input int x0, input int y0, input int r,
                              input bit inject);
        int done_cyc;
        int n;
        build_expect(x0, y0, r);
        got_a.delete();
        got_d.delete();
        got_c.delete();
        @(negedge clk);
        start  = 1'b1;
        cx     = 10'(x0);
        cy     = 9'(y0);
        radius = 6'(r);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 512'(busy), 512'(1));
        done_cyc = -1;
        for (int cyc = 1; cyc < 20000; cyc++) begin
            @(negedge clk);
            if (inject && cyc == 10) begin
                start  = 1'b1;
                cx     = 10'd7;
                cy     = 9'd7;
                radius = 6'd9;
            end
            if (inject && cyc == 11) start = 1'b0;
            if (we) begin
                got_a.push_back(write_addr);
                got_d.push_back(terrain_in);
                got_c.push_back(cyc);
            end
            if (done) begin
                done_cyc = cyc;
                chk("busy_at_done", 512'(busy), 512'(0));
                break;
            end
        end
        chk("done_seen", 512'(done_cyc > 0), 512'(1));
        chk("write_count", 512'(got_a.size()), 512'(exp_a.size()));
        n = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
        for (int k = 0; k < n; k++) begin
            chk("write_addr", 512'(got_a[k]), 512'(exp_a[k]));
            chk("write_data", got_d[k], exp_d[k]);
            chk("write_cycle", 512'(got_c[k]), 512'(exp_c[k]));
        end
        if (exp_a.size() == 0)
            chk("reject_done_cycle", 512'(done_cyc), 512'(1));
        else if (got_c.size() > 0)
            chk("done_after_write", 512'(done_cyc),
                512'(got_c[got_c.size()-1] + 1));
        @(negedge clk);
        chk("done_single_pulse", 512'(done), 512'(0));
        chk("busy_idle", 512'(busy), 512'(0));
    endtask

    initial begin
        int seen;
        reset_n   = 1'b0;
        start     = 1'b0;
        cx        = '0;
        cy        = '0;
        radius    = '0;
        fill_en   = 1'b0;
        fill_rand = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_we", 512'(we), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_read_addr", 512'(read_addr), 512'(0));
        chk("rst_write_addr", 512'(write_addr), 512'(0));
        chk("rst_terrain_in", terrain_in, 512'(0));
        reset_n = 1'b1;

        fill(1'b0);
        run_crater(100, 200, 0, 1'b0);
        run_crater(50, 100, 3, 1'b0);
        run_crater(1, 300, 4, 1'b0);
        run_crater(320, 2, 5, 1'b0);
        run_crater(320, 510, 5, 1'b0);
        run_crater(640, 0, 10, 1'b0);
        run_crater(639, 511, 63, 1'b0);
        fill(1'b0);
        run_crater(200, 256, 20, 1'b1);

        // Abort in the middle of the third column's write cycle.
        fill(1'b0);
        @(negedge clk);
        start  = 1'b1;
        cx     = 10'd300;
        cy     = 9'd256;
        radius = 6'd20;
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        for (int cyc = 0; cyc < 2000 && seen < 3; cyc++) begin
            @(negedge clk);
            if (we) seen++;
        end
        chk("abort_reached_write", 512'(seen), 512'(3));
        reset_n = 1'b0;
        #1;
        chk("abort_we", 512'(we), 512'(0));
        chk("abort_busy", 512'(busy), 512'(0));
        chk("abort_done", 512'(done), 512'(0));
        @(negedge clk);
        chk("abort_col_untouched", mem[282], {512{1'b1}});
        reset_n = 1'b1;
        @(negedge clk);
        chk("abort_no_done", 512'(done), 512'(0));
        run_crater(290, 250, 12, 1'b0);

        fill(1'b1);
        for (int i = 0; i < 6; i++) begin
            run_crater(int'($urandom_range(0, 700)), int'($urandom_range(0, 511)),
                       int'($urandom_range(0, 40)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
